// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit.
//   state_t     : sequencing controller states
//   CMD_*       : host command bytes accepted while waiting for a command
//   HALT_WORD_DEFAULT : instruction that terminates program loading
//   SEND_BYTES  : bytes in one PC + cycle-count report
package debug_pkg;

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_RUN      = 3'd3,
    ST_STEP     = 3'd4,
    ST_SEND     = 3'd5
  } state_t;

  localparam logic [7:0]  CMD_CONT          = 8'h43;  // 'C'
  localparam logic [7:0]  CMD_STEP          = 8'h53;  // 'S'
  localparam logic [7:0]  CMD_RESET         = 8'h52;  // 'R'
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          SEND_BYTES        = 8;

endpackage

// File: rtl/debug_unit_tx_serializer.sv
// tx_serializer: sends a 64-bit report as SEND_BYTES bytes, MSB first, over
// a start/done byte handshake.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : one-cycle pulse, capture i_word and start byte 0
//   i_word       : report word
//   i_tx_done    : transmitter finished the current byte
//   o_tx_data    : byte being transmitted
//   o_tx_start   : one-cycle pulse, start transmitting o_tx_data
//   o_done       : one-cycle pulse after the last byte's i_tx_done
module tx_serializer
  import debug_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [8*SEND_BYTES-1:0] i_word,
  input  logic                    i_tx_done,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_done
);

  localparam int WORD_W = 8 * SEND_BYTES;
  localparam int CNT_W  = $clog2(SEND_BYTES);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  left_q, left_d;  // bytes still to start after the current one
  logic              busy_q, busy_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              done_q, done_d;

  // NOTE: every signal gets a default before any branch, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    shift_d    = shift_q;
    left_d     = left_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    if (i_load) begin
      tx_data_d  = i_word[WORD_W-1 -: 8];
      shift_d    = i_word << 8;
      tx_start_d = 1'b1;
      left_d     = CNT_W'(SEND_BYTES - 1);
      busy_d     = 1'b1;
    end else if (busy_q && i_tx_done) begin
      if (left_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        tx_data_d  = shift_q[WORD_W-1 -: 8];
        shift_d    = shift_q << 8;
        tx_start_d = 1'b1;
        left_d     = left_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q    <= '0;
      left_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      left_q     <= left_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// debug_unit: host-facing sequencing controller for the MIPS pipeline.
// Assembles instructions from received bytes, writes them to instruction
// memory while the pipeline is held in reset, runs or steps the pipeline on
// command and reports PC and executed-cycle count back as 8 bytes.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_rx_data/i_rx_valid: received byte and its one-cycle strobe
//   i_tx_done           : transmitter finished the current byte
//   i_halt              : pipeline reached the halt instruction (level)
//   i_pc                : current pipeline PC
//   o_tx_data/o_tx_start: byte to send and its one-cycle start pulse
//   o_wea_mem_inst, o_addr_mem_inst, o_data_mem_inst : imem write port
//   o_mips_rst, o_mips_en : pipeline reset and clock enable
module debug_unit
  import debug_pkg::*;
#(
  parameter int             LEN       = 32,
  parameter int             NB_ADDR   = 10,
  parameter logic [LEN-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [LEN-1:0]     i_pc,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_wea_mem_inst,
  output logic [NB_ADDR-1:0] o_addr_mem_inst,
  output logic [LEN-1:0]     o_data_mem_inst,
  output logic               o_mips_rst,
  output logic               o_mips_en
);

  localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

  state_t             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [LEN-1:0]     word_q, word_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [31:0]        cycle_q, cycle_d;
  logic               load_q, load_d;      // first cycle of SEND: start report
  logic               wea_q, wea_d;
  logic               mips_rst_q, mips_rst_d;
  logic               mips_en;
  logic               ser_done;

  // Enable is decoded straight from state so the pipeline advances in the very
  // cycle the controller is in RUN/STEP.
  assign mips_en = (state_q == ST_RUN) || (state_q == ST_STEP);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    cycle_d    = cycle_q;
    if (mips_en) cycle_d = cycle_q + 32'd1;

    unique case (state_q)
      ST_LOAD: begin
        if (i_rx_valid) begin
          word_d     = {word_q[LEN-9:0], i_rx_data};
          byte_idx_d = byte_idx_q + 2'd1;  // wraps back to 0 after byte 3
          if (byte_idx_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The address saturates at the last word; loading stops there.
        if (addr_q != ADDR_MAX) addr_d = addr_q + NB_ADDR'(1);
        if (word_q == HALT_WORD || addr_q == ADDR_MAX) state_d = ST_WAIT_CMD;
        else                                           state_d = ST_LOAD;
      end
      ST_WAIT_CMD: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_CONT:  state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_RESET: begin
              state_d = ST_LOAD;
              addr_d  = '0;
              cycle_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt) state_d = ST_SEND;
      end
      ST_STEP: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) begin
          if (i_halt) begin
            state_d    = ST_LOAD;
            addr_d     = '0;
            cycle_d    = '0;
            byte_idx_d = '0;
          end else begin
            state_d = ST_WAIT_CMD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    load_d     = (state_d == ST_SEND) && (state_q != ST_SEND);
    wea_d      = (state_d == ST_WRITE);
    mips_rst_d = (state_d == ST_LOAD) || (state_d == ST_WRITE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_LOAD;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      cycle_q    <= '0;
      load_q     <= 1'b0;
      wea_q      <= 1'b0;
      mips_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      cycle_q    <= cycle_d;
      load_q     <= load_d;
      wea_q      <= wea_d;
      mips_rst_q <= mips_rst_d;
    end
  end

  // PC and count are captured in the first SEND cycle, after the last enabled
  // cycle has been counted.
  tx_serializer u_tx_serializer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load_q),
    .i_word     ({i_pc, cycle_q}),
    .i_tx_done  (i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_done     (ser_done)
  );

  assign o_wea_mem_inst  = wea_q;
  assign o_addr_mem_inst = addr_q;
  assign o_data_mem_inst = word_q;
  assign o_mips_rst      = mips_rst_q;
  assign o_mips_en       = mips_en;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: loads programs byte by byte, runs and
// steps the pipeline with randomized halt points, PCs and handshake delays,
// and compares memory writes, enable cycles and report bytes with a model.
module tb_debug_unit;
  import debug_pkg::*;

  localparam int          LEN     = 32;
  localparam int          NB_ADDR = 10;
  localparam int          DEPTH   = 1 << NB_ADDR;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic [7:0]         i_rx_data = '0;
  logic               i_rx_valid = 1'b0;
  logic               i_tx_done = 1'b0;
  logic               i_halt = 1'b0;
  logic [LEN-1:0]     i_pc = '0;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               o_wea_mem_inst;
  logic [NB_ADDR-1:0] o_addr_mem_inst;
  logic [LEN-1:0]     o_data_mem_inst;
  logic               o_mips_rst;
  logic               o_mips_en;

  always #5 clk = ~clk;

  debug_unit #(.LEN(LEN), .NB_ADDR(NB_ADDR), .HALT_WORD(HALT)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .i_tx_done       (i_tx_done),
    .i_halt          (i_halt),
    .i_pc            (i_pc),
    .o_tx_data       (o_tx_data),
    .o_tx_start      (o_tx_start),
    .o_wea_mem_inst  (o_wea_mem_inst),
    .o_addr_mem_inst (o_addr_mem_inst),
    .o_data_mem_inst (o_data_mem_inst),
    .o_mips_rst      (o_mips_rst),
    .o_mips_en       (o_mips_en)
  );

  int checks = 0;
  int errors = 0;

  logic [NB_ADDR+31:0] wr_q[$];   // observed {addr, data} writes
  logic [NB_ADDR+31:0] exp_wr[$]; // model writes for prog
  logic [31:0]         prog[$];
  logic [7:0]          tx_q[$];
  int                  en_total = 0;
  logic [31:0]         cnt_model = '0;  // cycles executed since last clear

  // Observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_wea_mem_inst) wr_q.push_back({o_addr_mem_inst, o_data_mem_inst});
    if (o_mips_en) en_total++;
    if (o_tx_start) tx_q.push_back(o_tx_data);
  end

  // Host transmitter model: answers each start with a done after 0..3 cycles.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      while (o_tx_start) begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // Writes the unit must perform for prog: sequential from 0, stopping at the
  // halt word or the last address.
  function automatic void model_load();
    int addr = 0;
    exp_wr.delete();
    foreach (prog[i]) begin
      exp_wr.push_back({addr[NB_ADDR-1:0], prog[i]});
      if (prog[i] == HALT || addr == DEPTH - 1) break;
      addr++;
    end
  endfunction

  function automatic logic [7:0] junk_byte();
    logic [7:0] b = 8'($urandom_range(0, 255));
    if (b == CMD_CONT || b == CMD_STEP || b == CMD_RESET) b = 8'h41;
    return b;
  endfunction

  task automatic make_prog(input int n, input bit add_halt);
    logic [31:0] w;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      prog.push_back(w);
    end
    if (add_halt) prog.push_back(HALT);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic load_program();
    wr_q.delete();
    model_load();
    foreach (prog[k]) begin
      for (int i = 3; i >= 0; i--) begin
        send_byte(prog[k][8*i +: 8]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  // Issues cmd; for 'C' raises i_halt on the n_halt-th enabled cycle. Injects
  // a random byte during RUN and during SEND. Returns enabled cycles seen.
  task automatic exec_cmd(input logic [7:0] cmd, input int n_halt, output int en_seen);
    int seen = 0;
    int start = en_total;
    bit junk_run = 1'b0;
    bit junk_send = 1'b0;
    tx_q.delete();
    send_byte(cmd);
    for (int c = 0; c < 400; c++) begin
      i_rx_valid = 1'b0;
      if (o_mips_en) begin
        seen++;
        if (seen == n_halt) i_halt = 1'b1;
        if (seen == 2 && !junk_run) begin
          junk_run = 1'b1; i_rx_data = 8'($urandom); i_rx_valid = 1'b1;
        end
      end
      if (tx_q.size() == 3 && !junk_send) begin
        junk_send = 1'b1; i_rx_data = 8'($urandom); i_rx_valid = 1'b1;
      end
      if (tx_q.size() == SEND_BYTES) break;
      @(negedge clk);
    end
    i_rx_valid = 1'b0;
    repeat (12) @(negedge clk);
    en_seen = en_total - start;
  endtask

  task automatic test_reset();
    logic [NB_ADDR+LEN+11:0] got;
    @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {o_tx_start, o_wea_mem_inst, o_addr_mem_inst, o_data_mem_inst,
           o_tx_data, o_mips_en, o_mips_rst};
    checks++;
    if (got !== {2'b00, {NB_ADDR{1'b0}}, {LEN{1'b0}}, 8'h00, 2'b01}) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", got,
               {2'b00, {NB_ADDR{1'b0}}, {LEN{1'b0}}, 8'h00, 2'b01});
    end
    i_rst = 1'b0;
    cnt_model = '0;
  endtask

  task automatic test_load();
    prog = '{32'h2008_0005, 32'h2009_0007, HALT};
    load_program();
    checks++;
    if (wr_q.size() != 3) begin
      errors++; $display("FAIL load_count got %0d exp 3", wr_q.size());
    end else begin
      foreach (exp_wr[i]) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          errors++; $display("FAIL load_word%0d got %h exp %h", i, wr_q[i], exp_wr[i]);
        end
      end
    end
    checks++;
    if (o_mips_rst !== 1'b0 || o_mips_en !== 1'b0) begin
      errors++; $display("FAIL load_wait_cmd got rst=%b en=%b exp rst=0 en=0", o_mips_rst, o_mips_en);
    end
  endtask

  task automatic test_run_plan();
    int en;
    logic [63:0] exp = {32'h0000_0008, 32'd6};
    i_pc = 32'h0000_0008;
    exec_cmd(CMD_CONT, 6, en);
    checks++;
    if (en != 6) begin errors++; $display("FAIL run_plan_en got %0d exp 6", en); end
    checks++;
    if (tx_q.size() != SEND_BYTES) begin
      errors++; $display("FAIL run_plan_tx_count got %0d exp 8", tx_q.size());
    end else begin
      for (int i = 0; i < SEND_BYTES; i++) begin
        checks++;
        if (tx_q[i] !== exp[63-8*i -: 8]) begin
          errors++; $display("FAIL run_plan_byte%0d got %h exp %h", i, tx_q[i], exp[63-8*i -: 8]);
        end
      end
    end
    checks++;
    if (o_mips_rst !== 1'b1) begin errors++; $display("FAIL run_plan_to_load got rst=%b exp 1", o_mips_rst); end
    i_halt = 1'b0;
    cnt_model = '0;
  endtask

  task automatic test_step();
    int en;
    int en_before;
    int wr_before;
    logic [63:0] exp;
    make_prog($urandom_range(1, 6), 1'b1);
    load_program();
    checks++;
    if (wr_q.size() != exp_wr.size() || o_mips_rst !== 1'b0) begin
      errors++; $display("FAIL step_load got writes=%0d rst=%b exp writes=%0d rst=0", wr_q.size(), o_mips_rst, exp_wr.size());
    end
    // A non-command byte in WAIT_CMD must change nothing.
    en_before = en_total; wr_before = wr_q.size(); tx_q.delete();
    send_byte(8'h41);
    repeat (6) @(negedge clk);
    checks++;
    if (en_total != en_before || tx_q.size() != 0 || wr_q.size() != wr_before || o_mips_rst !== 1'b0) begin
      errors++; $display("FAIL ignore_byte got en=%0d tx=%0d wr=%0d rst=%b exp en=%0d tx=0 wr=%0d rst=0",
                         en_total - en_before, tx_q.size(), wr_q.size(), o_mips_rst, 0, wr_before);
    end
    for (int k = 1; k <= 3; k++) begin
      i_pc = $urandom;
      exec_cmd(CMD_STEP, 0, en);
      cnt_model = cnt_model + 32'd1;
      exp = {i_pc, cnt_model};
      checks++;
      if (en != 1) begin errors++; $display("FAIL step%0d_en got %0d exp 1", k, en); end
      checks++;
      if (tx_q.size() != SEND_BYTES) begin
        errors++; $display("FAIL step%0d_tx_count got %0d exp 8", k, tx_q.size());
      end else begin
        for (int i = 0; i < SEND_BYTES; i++) begin
          checks++;
          if (tx_q[i] !== exp[63-8*i -: 8]) begin
            errors++; $display("FAIL step%0d_byte%0d got %h exp %h", k, i, tx_q[i], exp[63-8*i -: 8]);
          end
        end
      end
      checks++;
      if (o_mips_rst !== 1'b0) begin errors++; $display("FAIL step%0d_stay_wait got rst=%b exp 0", k, o_mips_rst); end
    end
  endtask

  task automatic test_cmd_reset();
    int en;
    logic [63:0] exp;
    send_byte(CMD_RESET);
    repeat (2) @(negedge clk);
    cnt_model = '0;
    checks++;
    if (o_mips_rst !== 1'b1) begin errors++; $display("FAIL cmd_reset_rst got %b exp 1", o_mips_rst); end
    make_prog(2, 1'b1);
    load_program();
    checks++;
    if (wr_q.size() != 3 || wr_q[0] !== exp_wr[0]) begin
      errors++; $display("FAIL cmd_reset_addr0 got n=%0d first=%h exp n=3 first=%h", wr_q.size(),
                         (wr_q.size() > 0) ? wr_q[0] : '0, exp_wr[0]);
    end
    i_pc = $urandom;
    exec_cmd(CMD_STEP, 0, en);
    cnt_model = cnt_model + 32'd1;
    exp = {i_pc, cnt_model};
    checks++;
    if (tx_q.size() != SEND_BYTES || {tx_q[4], tx_q[5], tx_q[6], tx_q[7]} !== exp[31:0]) begin
      errors++; $display("FAIL cmd_reset_count got n=%0d exp count %h", tx_q.size(), exp[31:0]);
    end
  endtask

  task automatic test_run_random();
    int en;
    int n;
    int n_steps;
    logic [63:0] exp;
    send_byte(CMD_RESET);
    cnt_model = '0;
    for (int it = 0; it < 5; it++) begin
      make_prog($urandom_range(0, 5), 1'b1);
      load_program();
      n_steps = $urandom_range(0, 2);
      for (int s = 0; s < n_steps; s++) begin
        i_pc = $urandom;
        exec_cmd(CMD_STEP, 0, en);
        cnt_model = cnt_model + 32'd1;
      end
      n = $urandom_range(0, 12);
      if (n == 0) i_halt = 1'b1;  // halted on entry: one enabled cycle
      i_pc = $urandom;
      exec_cmd(CMD_CONT, n, en);
      cnt_model = cnt_model + 32'((n == 0) ? 1 : n);
      exp = {i_pc, cnt_model};
      checks++;
      if (en != ((n == 0) ? 1 : n)) begin
        errors++; $display("FAIL rand%0d_en got %0d exp %0d", it, en, (n == 0) ? 1 : n);
      end
      checks++;
      if (tx_q.size() != SEND_BYTES) begin
        errors++; $display("FAIL rand%0d_tx_count got %0d exp 8", it, tx_q.size());
      end else begin
        for (int i = 0; i < SEND_BYTES; i++) begin
          checks++;
          if (tx_q[i] !== exp[63-8*i -: 8]) begin
            errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", it, i, tx_q[i], exp[63-8*i -: 8]);
          end
        end
      end
      checks++;
      if (o_mips_rst !== 1'b1) begin errors++; $display("FAIL rand%0d_to_load got rst=%b exp 1", it, o_mips_rst); end
      i_halt = 1'b0;
      cnt_model = '0;
    end
  endtask

  task automatic test_reset_midload();
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    cnt_model = '0;
    prog = '{32'h0000_0001, HALT};
    load_program();
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {{NB_ADDR{1'b0}}, 32'h0000_0001}) begin
      errors++; $display("FAIL midload_reset got n=%0d first=%h exp n=2 first=%h", wr_q.size(),
                         (wr_q.size() > 0) ? wr_q[0] : '0, {{NB_ADDR{1'b0}}, 32'h0000_0001});
    end
  endtask

  task automatic test_mem_full();
    int wr_before;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    make_prog(DEPTH, 1'b0);
    load_program();
    checks++;
    if (wr_q.size() != DEPTH) begin
      errors++; $display("FAIL full_count got %0d exp %0d", wr_q.size(), DEPTH);
    end else begin
      foreach (exp_wr[i]) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          errors++; $display("FAIL full_word%0d got %h exp %h", i, wr_q[i], exp_wr[i]);
        end
      end
    end
    checks++;
    if (o_mips_rst !== 1'b0) begin errors++; $display("FAIL full_wait_cmd got rst=%b exp 0", o_mips_rst); end
    wr_before = wr_q.size();
    for (int i = 0; i < 4; i++) send_byte(junk_byte());
    repeat (4) @(negedge clk);
    checks++;
    if (wr_q.size() != wr_before || o_mips_rst !== 1'b0) begin
      errors++; $display("FAIL full_extra_bytes got writes=%0d rst=%b exp writes=%0d rst=0",
                         wr_q.size(), o_mips_rst, wr_before);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_plan();
    test_step();
    test_cmd_reset();
    test_run_random();
    test_reset_midload();
    test_mem_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
